// File: rtl/automatic_dish_washing_machine_if.sv
`default_nettype none
// ============================================================================
// Module      : automatic_dish_washing_machine_if
// Description : Sensor/timer inputs and actuator outputs of the dish washer
//               controller, bundled as one interface.
//               slave  : controller side (sensors in, actuators out)
//               master : environment side (drives sensors, observes actuators)
// Ports       : Start, Classify, Filled, Drained, Detergent_Added,
//               Washing_Timeout, Store_Timeout (to controller);
//               Fill_valve_second_on, Fill_valve_on, Drained_valve_on,
//               Door_Lock, Done, out (from controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface automatic_dish_washing_machine_if;
    logic Start;
    logic Classify;
    logic Filled;
    logic Drained;
    logic Detergent_Added;
    logic Washing_Timeout;
    logic Store_Timeout;
    logic Fill_valve_second_on;
    logic Fill_valve_on;
    logic Drained_valve_on;
    logic Door_Lock;
    logic Done;
    logic out;

    modport slave (
        input  Start, Classify, Filled, Drained, Detergent_Added,
               Washing_Timeout, Store_Timeout,
        output Fill_valve_second_on, Fill_valve_on, Drained_valve_on,
               Door_Lock, Done, out
    );

    modport master (
        output Start, Classify, Filled, Drained, Detergent_Added,
               Washing_Timeout, Store_Timeout,
        input  Fill_valve_second_on, Fill_valve_on, Drained_valve_on,
               Door_Lock, Done, out
    );
endinterface
`default_nettype wire

// File: rtl/automatic_dish_washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : automatic_dish_washing_machine
// Description : Moore FSM sequencing IDLE -> FILL -> DETERGENT -> WASH ->
//               DRAIN -> STORE -> DONE -> IDLE. Each state waits only on its
//               own exit input; outputs decode from the registered state.
// Ports       : Clock - system clock (rising edge)
//               Reset - asynchronous active-low reset
//               bus   - sensor inputs / actuator outputs (slave modport)
// Parameters  : DONE_CYCLES - cycles spent in DONE (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module automatic_dish_washing_machine #(
    parameter int unsigned DONE_CYCLES = 1
) (
    input  wire logic                            Clock,
    input  wire logic                            Reset,
    automatic_dish_washing_machine_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_DETERGENT = 3'd2,
        S_WASH      = 3'd3,
        S_DRAIN     = 3'd4,
        S_STORE     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    // Counter value on the final DONE cycle.
    localparam logic [3:0] C_DONE_LAST = 4'(DONE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:      if (bus.Start && bus.Classify) state_d = S_FILL;
            S_FILL:      if (bus.Filled)                state_d = S_DETERGENT;
            S_DETERGENT: if (bus.Detergent_Added)       state_d = S_WASH;
            S_WASH:      if (bus.Washing_Timeout)       state_d = S_DRAIN;
            S_DRAIN:     if (bus.Drained)               state_d = S_STORE;
            S_STORE: begin
                if (bus.Store_Timeout) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end
            end
            S_DONE: begin
                if (cnt_q == C_DONE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Moore output decode: depends on state_q only, so reset clears the
    // outputs immediately without waiting for a clock edge.
    logic w_fill_second;
    logic w_fill;
    logic w_drain;
    logic w_lock;
    logic w_done;

    always_comb begin
        w_fill_second = 1'b0;
        w_fill        = 1'b0;
        w_drain       = 1'b0;
        w_lock        = 1'b0;
        w_done        = 1'b0;
        case (state_q)
            S_FILL:      begin w_fill        = 1'b1; w_lock = 1'b1; end
            S_DETERGENT: begin w_fill_second = 1'b1; w_lock = 1'b1; end
            S_WASH:      w_lock = 1'b1;
            S_DRAIN:     begin w_drain       = 1'b1; w_lock = 1'b1; end
            S_STORE:     w_lock = 1'b1;
            S_DONE:      w_done = 1'b1;  // door released
            default:     ;
        endcase
    end

    assign bus.Fill_valve_second_on = w_fill_second;
    assign bus.Fill_valve_on        = w_fill;
    assign bus.Drained_valve_on     = w_drain;
    assign bus.Door_Lock            = w_lock;
    assign bus.Done                 = w_done;
    assign bus.out                  = w_fill_second | w_fill | w_drain | w_lock | w_done;

endmodule
`default_nettype wire

// File: tb/tb_automatic_dish_washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_automatic_dish_washing_machine
// Description : Drives two controllers (DONE_CYCLES=1 and 3) with identical
//               stimulus and compares every output against a phase-index
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_automatic_dish_washing_machine;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    // Input vector: 0 Start, 1 Classify, 2 Filled, 3 Detergent_Added,
    // 4 Washing_Timeout, 5 Drained, 6 Store_Timeout.
    // Phase k (1..5) exits on bit k+1.
    logic [6:0] in_v = 7'd0;

    automatic_dish_washing_machine_if if_a ();
    automatic_dish_washing_machine_if if_b ();

    assign if_a.Start = in_v[0];           assign if_b.Start = in_v[0];
    assign if_a.Classify = in_v[1];        assign if_b.Classify = in_v[1];
    assign if_a.Filled = in_v[2];          assign if_b.Filled = in_v[2];
    assign if_a.Detergent_Added = in_v[3]; assign if_b.Detergent_Added = in_v[3];
    assign if_a.Washing_Timeout = in_v[4]; assign if_b.Washing_Timeout = in_v[4];
    assign if_a.Drained = in_v[5];         assign if_b.Drained = in_v[5];
    assign if_a.Store_Timeout = in_v[6];   assign if_b.Store_Timeout = in_v[6];

    automatic_dish_washing_machine #(.DONE_CYCLES(1)) u_dut_a (
        .Clock (Clock), .Reset (Reset), .bus (if_a.slave));
    automatic_dish_washing_machine #(.DONE_CYCLES(3)) u_dut_b (
        .Clock (Clock), .Reset (Reset), .bus (if_b.slave));

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 = IDLE ... 6 = DONE.
    int phase [2];
    int dleft [2];
    int dcyc  [2] = '{1, 3};

    // Expected {second, fill, drain, lock, done, out} per phase.
    function automatic logic [5:0] exp_out(int p);
        logic [5:0] t [7];
        t[0] = 6'b000000; t[1] = 6'b010101; t[2] = 6'b100101;
        t[3] = 6'b000101; t[4] = 6'b001101; t[5] = 6'b000101;
        t[6] = 6'b000011;
        return t[p];
    endfunction

    function automatic logic [5:0] obs_a();
        return {if_a.Fill_valve_second_on, if_a.Fill_valve_on, if_a.Drained_valve_on,
                if_a.Door_Lock, if_a.Done, if_a.out};
    endfunction
    function automatic logic [5:0] obs_b();
        return {if_b.Fill_valve_second_on, if_b.Fill_valve_on, if_b.Drained_valve_on,
                if_b.Door_Lock, if_b.Done, if_b.out};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (phase[k] == 0) begin
                if (in_v[0] && in_v[1]) phase[k] = 1;
            end else if (phase[k] <= 5) begin
                if (in_v[phase[k] + 1]) begin
                    phase[k] = phase[k] + 1;
                    if (phase[k] == 6) dleft[k] = dcyc[k];
                end
            end else begin
                dleft[k] = dleft[k] - 1;
                if (dleft[k] == 0) phase[k] = 0;
            end
        end
    endtask

    task automatic check(string tag);
        logic [5:0] oa, ob, ea, eb;
        oa = obs_a(); ob = obs_b();
        ea = exp_out(phase[0]); eb = exp_out(phase[1]);
        checks++;
        assert (oa === ea) else begin
            failures++;
            $error("FAIL %s dut_a observed=%b expected=%b", tag, oa, ea);
        end
        checks++;
        assert (ob === eb) else begin
            failures++;
            $error("FAIL %s dut_b observed=%b expected=%b", tag, ob, eb);
        end
    endtask

    // Advance one rising edge, update the model, check 1 time unit later.
    task automatic step(string tag);
        @(posedge Clock);
        if (Reset) model_edge();
        #1;
        check(tag);
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic mid_reset(string tag);
        @(posedge Clock);
        if (Reset) model_edge();
        #2;
        Reset = 1'b0;
        phase[0] = 0; phase[1] = 0;
        #1;
        check(tag);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        phase[0] = 0; phase[1] = 0; dleft[0] = 0; dleft[1] = 0;

        // Reset held low two cycles with Start/Classify high.
        in_v = 7'b0000011;
        #1; check("reset_async");
        step("reset_hold1");
        step("reset_hold2");
        @(negedge Clock); Reset = 1'b1;
        step("first_fill");

        // Full cycle with single-cycle pulses.
        mid_reset("reset_before_full");
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            in_v = (i == 0) ? 7'b0000011 : 7'(1 << (i + 1));
            step("full_pulse");
            @(negedge Clock);
            in_v = 7'd0;
            step("full_idle");
        end
        repeat (4) step("full_tail");

        // Start without Classify is ignored.
        @(negedge Clock); in_v = 7'b0000001;
        repeat (5) step("start_no_classify");

        // Drive to WASH, then assert every non-exit input.
        @(negedge Clock); in_v = 7'b0000011; step("to_fill");
        @(negedge Clock); in_v = 7'b0000100; step("to_det");
        @(negedge Clock); in_v = 7'b0001000; step("to_wash");
        @(negedge Clock); in_v = 7'b0101111;
        repeat (3) step("wash_ignore");
        @(negedge Clock); in_v = 7'b0010000; step("wash_to_drain");
        @(negedge Clock); in_v = 7'd0; step("drain_hold");

        // Reset in DRAIN, then verify the machine stays idle.
        mid_reset("drain_reset");
        step("after_drain_reset");

        // All inputs high: one cycle per phase, DONE length per instance.
        @(negedge Clock); in_v = 7'h7F;
        repeat (14) step("all_high");
        @(negedge Clock); in_v = 7'd0;
        repeat (4) step("all_high_tail");

        // Randomized stimulus with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            in_v = 7'($urandom);
            if ($urandom_range(0, 39) == 0) mid_reset("rand_reset");
            else step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/automatic_dish_washing_machine.md
Name: automatic_dish_washing_machine

Overview:
- Moore FSM controller for an automatic dish washer.
- Sequences fill, detergent, wash, drain and store/dry phases from sensor and timer inputs.
- Drives the valve, door-lock and done outputs.
- Also produces a single aggregate activity flag, `out`, equal to the OR of all five control outputs, for the front-panel indicator.

Parameters:
- DONE_CYCLES, default 1: number of clock cycles the DONE state is held (and Done asserted) before returning to IDLE; legal range 1..15.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  start request, sampled only in IDLE.
- Classify  input  1  door-closed/load-classified qualifier; must be 1 together with Start.
- Filled  input  1  water-level sensor: tub full.
- Drained  input  1  water-level sensor: tub empty.
- Detergent_Added  input  1  detergent dispenser complete.
- Washing_Timeout  input  1  external wash timer expired.
- Store_Timeout  input  1  external store/dry timer expired.
- Fill_valve_second_on  output  1  second (detergent-line) inlet valve open.
- Fill_valve_on  output  1  main water inlet valve open.
- Drained_valve_on  output  1  drain valve open.
- Door_Lock  output  1  door locked.
- Done  output  1  cycle complete.
- out  output  1  OR of the five outputs above.

Behaviour:
- States: IDLE, FILL, DETERGENT, WASH, DRAIN, STORE, DONE (3-bit binary encoding).
- Reset (Reset=0, asynchronous):
  - state goes to IDLE immediately.
  - done-hold counter is cleared.
  - all outputs are 0 while Reset is low, regardless of Clock.
- Outputs are a pure function of the registered state (Moore). They change only on a Clock rising edge or on assertion of reset. No combinational input-to-output path.
- Output decode (all unlisted outputs are 0):
  - IDLE: all 0.
  - FILL: Fill_valve_on=1, Door_Lock=1.
  - DETERGENT: Fill_valve_second_on=1, Door_Lock=1.
  - WASH: Door_Lock=1.
  - DRAIN: Drained_valve_on=1, Door_Lock=1.
  - STORE: Door_Lock=1.
  - DONE: Done=1; Door_Lock=0, so the door is released.
- out = Fill_valve_second_on | Fill_valve_on | Drained_valve_on | Door_Lock | Done. It is combinational from the registered outputs.
- Transitions, evaluated on each rising edge; the state holds otherwise:
  - IDLE -> FILL when Start=1 and Classify=1. Start with Classify=0 is ignored.
  - FILL -> DETERGENT when Filled=1.
  - DETERGENT -> WASH when Detergent_Added=1.
  - WASH -> DRAIN when Washing_Timeout=1.
  - DRAIN -> STORE when Drained=1.
  - STORE -> DONE when Store_Timeout=1. The done counter loads 0.
  - DONE: the counter increments each cycle; -> IDLE after DONE_CYCLES cycles in DONE. With the default, DONE lasts exactly one cycle.
- Each state examines only its own exit input. All other inputs are ignored, including when several are asserted simultaneously. Examples: Start during WASH has no effect; Filled=1 in IDLE has no effect.
- At most one state advance per clock, even if the next state's input is already high. With every input held high from IDLE, the sequence visits each state for one cycle.
- Latency: an input sampled high at edge N changes the outputs immediately after edge N.
- Inputs are level-sensitive; no edge detection is required.
- Reset mid-cycle, in any state: immediate return to IDLE with all outputs 0. The machine restarts only on a fresh Start and Classify.

Test Plan:
- Reset held low for 2 cycles with Start=Classify=1 -> all outputs 0 and out=0 throughout. After release plus one edge with Start=Classify=1 -> Fill_valve_on=1, Door_Lock=1, out=1.
- Full cycle, each input pulsed for one cycle in order (Start+Classify, Filled, Detergent_Added, Washing_Timeout, Drained, Store_Timeout) -> the outputs step through:
  - Fill_valve_on+Door_Lock
  - Fill_valve_second_on+Door_Lock
  - Door_Lock
  - Drained_valve_on+Door_Lock
  - Door_Lock
  - Done=1 for exactly 1 cycle, then all 0.
- Start=1 with Classify=0 for 5 cycles -> stays IDLE, all outputs 0.
- In WASH, assert Filled, Drained, Detergent_Added and Start together without Washing_Timeout -> stays in WASH with Door_Lock=1 only. Then assert Washing_Timeout -> DRAIN.
- In DRAIN, drive Reset=0 between clock edges -> Drained_valve_on and Door_Lock drop to 0 immediately. After release -> IDLE.
- All inputs held at 1 from IDLE, with DONE_CYCLES=3 -> one cycle each in FILL through STORE, Done=1 for 3 cycles, then IDLE. The next edge re-enters FILL.
